mux_4x1_rr_arbiter: RTL and testbench
=====================================

// Module: mux_4x1_rr_arbiter
// PURPOSE
//   Round-robin arbiter and select controller for a 4:1 data mux. Four requesters
//   compete for one shared output path. The block owns the mux select lines
//   (s1,s0), holds a grant while its owner keeps requesting, and steers that
//   owner's data to dout. It sits in front of a shared sink (bus, UART or display).
// PARAMETERS
//   DW        8   data width per requester and of dout
//   MAX_HOLD  8   max consecutive grant cycles while others wait (ARB_TIMEOUT_EN only)
// PORTS
//   clk    in   1     rising-edge clock
//   rst_n  in   1     reset, asynchronous, active-low
//   req    in   4     request bit per requester, level-sensitive
//   i0     in   DW    data from requester 0
//   i1     in   DW    data from requester 1
//   i2     in   DW    data from requester 2
//   i3     in   DW    data from requester 3
//   gnt    out  4     one-hot grant, registered
//   s1     out  1     mux select MSB, registered
//   s0     out  1     mux select LSB, registered
//   valid  out  1     a grant is active this cycle, registered
//   dout   out  DW    {s1,s0}-selected input when valid=1, else 0 (combinational)
// BEHAVIOUR
//   - Reset: gnt=0000, {s1,s0}=00, valid=0, dout=0, last=3, state=IDLE, hold_cnt=0.
//   - FSM has two states: IDLE and GRANT.
//     IDLE: if req!=0, pick a winner; next edge sets gnt, {s1,s0} and valid=1, and
//     goes to GRANT. Latency is 1 clock from req to gnt.
//   - Winner: the first set req bit searching last+1, last+2, ... mod 4.
//     last is updated to the winner's index when the grant is issued.
//   - GRANT, req[owner]=1: hold gnt, {s1,s0} and valid. Other requests wait.
//   - GRANT, req[owner]=0: if any other req is set, the next edge grants the next
//     winner directly (no idle bubble). Otherwise go to IDLE, with gnt=0 and
//     valid=0 on that edge.
//   - The released owner can only win again after the other requesters, by rotation.
//   - {s1,s0} holds its last value in IDLE; dout is forced to 0 whenever valid=0.
//   - req changes within a cycle are sampled only at the edge. At most one gnt bit
//     is ever set.
//   - Reset asserted mid-grant: all outputs clear immediately (asynchronous).
//     After release, the first grant goes to the lowest requesting index,
//     starting from 0.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     - hold_cnt ($clog2(MAX_HOLD+1) bits) loads 1 on each new grant and
//       increments each cycle the owner keeps the grant.
//     - When hold_cnt==MAX_HOLD and another req is set, the next edge rotates the
//       grant even though req[owner]=1.
//     - With no other request pending, the owner keeps the grant and hold_cnt
//       saturates at MAX_HOLD.
//   ARB_TIMEOUT_EN undefined: no counter; the owner holds the grant indefinitely.
// STRUCTURE
//   - Shared header mux_arb_defs.vh holds: state encodings ST_IDLE=1'b0,
//     ST_GRANT=1'b1; NREQ=4; the select width.
//   - Sub-module rr_pick4 is combinational: (req[3:0], last[1:0], mask_owner)
//     -> (any, idx[1:0]).
//   - Top level: FSM, last/sel/gnt registers, optional hold counter, output mux.
// TESTING
//   1. Reset: rst_n=0 with req=1111 -> gnt=0000, {s1,s0}=00, valid=0, dout=00.
//   2. Single request: req=0100, i2=8'hA5 -> next edge gnt=0100, {s1,s0}=10,
//      valid=1, dout=A5.
//   3. Rotation: req=1111, owner drops its req for one cycle after each grant
//      -> grant order 0,1,2,3,0 with no idle cycles between grants.
//   4. Release with no others: req 0010 -> 0000 -> next edge gnt=0000, valid=0,
//      dout=0; then req=0011 -> grant goes to 0 (last=1).
//   5. Mid-grant reset: gnt=0010, pulse rst_n low -> outputs clear immediately;
//      after release, req=1010 -> gnt=0010.
//   6. ARB_TIMEOUT_EN, MAX_HOLD=4: req=0011 held -> gnt=0001 for 4 cycles, then
//      gnt=0010. Without the macro, gnt=0001 persists for 20 or more cycles.

Source files
------------

// File: rtl/mux_4x1_rr_arbiter_pkg.sv
// Shared definitions for the 4:1 round-robin mux arbiter: state encoding,
// requester count, select width and a one-hot helper.
package mux_4x1_rr_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NREQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_4x1_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request searching last+1,
// last+2, ... (mod 4). With mask_owner set, index 'last' itself is skipped,
// so only the other requesters can win.
module rr_pick4
  import mux_4x1_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  input  logic             mask_owner,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk the four rotated positions; the first hit wins.
  always_comb begin
    any  = 1'b0;
    idx  = last;
    cand = last;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last + SEL_W'(k);
      if (!any && req[cand] && !(mask_owner && (k == NREQ))) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter and select controller for a 4:1 data mux.
// Optional feature: define ARB_TIMEOUT_EN to bound how long one owner may
// hold the grant (MAX_HOLD cycles) while other requesters are waiting.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | no grant active; next set request wins on the next edge
//   ST_GRANT | one owner holds gnt/{s1,s0}; released or rotated on drop
module mux_4x1_rr_arbiter
  import mux_4x1_rr_arbiter_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [DW-1:0]   i0,
  input  logic [DW-1:0]   i1,
  input  logic [DW-1:0]   i2,
  input  logic [DW-1:0]   i3,
  output logic [3:0]      gnt,
  output logic            s1,
  output logic            s0,
  output logic            valid,
  output logic [DW-1:0]   dout
);

  arb_state_t       state;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] sel;
  logic             owner_req;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             timeout;
  logic             take;
  logic             drop;

  assign sel       = {s1, s0};
  assign owner_req = req[sel];

  // While granting, the owner is masked so only the others compete; last
  // always equals the owner's index in that state.
  rr_pick4 u_pick (
    .req        (req),
    .last       (last),
    .mask_owner (state == ST_GRANT),
    .any        (pick_any),
    .idx        (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);
  logic [HCW-1:0] hold_cnt;

  assign timeout = (hold_cnt == HCW'(MAX_HOLD));

  // Count consecutive grant cycles of the current owner, saturating at MAX_HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (take) begin
      hold_cnt <= HCW'(1);
    end else if ((state == ST_GRANT) && owner_req && !timeout) begin
      hold_cnt <= hold_cnt + HCW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Decide whether this edge issues a new grant or returns to idle.
  always_comb begin
    take = 1'b0;
    drop = 1'b0;
    case (state)
      ST_IDLE: take = pick_any;
      ST_GRANT: begin
        if (!owner_req || timeout) begin
          take = pick_any;
          drop = !owner_req && !pick_any;
        end
      end
      default: take = 1'b0;
    endcase
  end

  // Arbitration FSM with registered grant, select and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
      s1    <= 1'b0;
      s0    <= 1'b0;
      valid <= 1'b0;
      last  <= SEL_W'(NREQ - 1);
    end else if (take) begin
      state     <= ST_GRANT;
      gnt       <= idx2onehot(pick_idx);
      {s1, s0}  <= pick_idx;
      valid     <= 1'b1;
      last      <= pick_idx;
    end else if (drop) begin
      state <= ST_IDLE;
      gnt   <= '0;
      valid <= 1'b0;
    end
  end

  // Steer the selected requester's data out; zero whenever no grant is active.
  always_comb begin
    dout = '0;
    if (valid) begin
      case (sel)
        2'd0:    dout = i0;
        2'd1:    dout = i1;
        2'd2:    dout = i2;
        default: dout = i3;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Bench for mux_4x1_rr_arbiter: a cycle-level reference model built from the
// round-robin rules, compared against the DUT every cycle, plus directed
// literal expectations at key points.
module tb_mux_4x1_rr_arbiter;

  localparam int DW   = 8;
  localparam int MAXH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] i0, i1, i2, i3;
  logic [3:0]    gnt;
  logic          s1, s0, valid;
  logic [DW-1:0] dout;

  int checks = 0;
  int errors = 0;

  mux_4x1_rr_arbiter #(.DW(DW), .MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .i3    (i3),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .valid (valid),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  // Reference model: owner index, last winner, hold length.
  int         m_last  = 3;
  int         m_cnt   = 0;
  logic [3:0] m_gnt   = 4'b0000;
  logic [1:0] m_sel   = 2'b00;
  logic       m_valid = 1'b0;
  int         win;
  int         c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = 3; m_cnt = 0; m_gnt = 4'b0000; m_sel = 2'b00; m_valid = 1'b0;
    end else begin
      win = -1;
      if (!m_valid) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (win < 0 && req[c]) win = c;
        end
      end else begin
        for (int k = 1; k <= 3; k++) begin
          c = (int'(m_sel) + k) % 4;
          if (win < 0 && req[c]) win = c;
        end
        if (req[m_sel] && !(TO && win >= 0 && m_cnt >= MAXH)) begin
          win = -2;
          if (m_cnt < MAXH) m_cnt = m_cnt + 1;
        end
      end
      if (win >= 0) begin
        m_sel = 2'(win); m_last = win; m_gnt = 4'b0001 << win;
        m_valid = 1'b1; m_cnt = 1;
      end else if (win == -1) begin
        m_valid = 1'b0; m_gnt = 4'b0000;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [DW-1:0] ed;
    logic [DW-1:0] din [4];
    din[0] = i0; din[1] = i1; din[2] = i2; din[3] = i3;
    ed = m_valid ? din[m_sel] : '0;
    checks++;
    if (gnt !== m_gnt || {s1, s0} !== m_sel || valid !== m_valid || dout !== ed) begin
      errors++;
      $display("FAIL model_cmp t=%0t got gnt=%b sel=%b valid=%b dout=%h exp gnt=%b sel=%b valid=%b dout=%h",
               $time, gnt, {s1, s0}, valid, dout, m_gnt, m_sel, m_valid, ed);
    end
  end

  task automatic chk(input string nm, input logic [3:0] eg, input logic [1:0] es,
                     input logic ev, input logic [DW-1:0] ed);
    checks++;
    if (gnt !== eg || {s1, s0} !== es || valid !== ev || dout !== ed) begin
      errors++;
      $display("FAIL %s t=%0t got gnt=%b sel=%b valid=%b dout=%h exp gnt=%b sel=%b valid=%b dout=%h",
               nm, $time, gnt, {s1, s0}, valid, dout, eg, es, ev, ed);
    end
  endtask

  // Drive req, let one edge sample it, then settle just after the falling edge.
  task automatic tick(input logic [3:0] r);
    req = r;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    i0 = 8'h11; i1 = 8'h22; i2 = 8'hA5; i3 = 8'h3C;
    repeat (2) @(negedge clk);
    #1;
    chk("reset", 4'b0000, 2'b00, 1'b0, 8'h00);
    rst_n = 1'b1;

    // Rotation with each owner dropping for one cycle
    tick(4'b1111); chk("rot0", 4'b0001, 2'b00, 1'b1, 8'h11);
    tick(4'b1110); chk("rot1", 4'b0010, 2'b01, 1'b1, 8'h22);
    tick(4'b1101); chk("rot2", 4'b0100, 2'b10, 1'b1, 8'hA5);
    tick(4'b1011); chk("rot3", 4'b1000, 2'b11, 1'b1, 8'h3C);
    tick(4'b0111); chk("rot4", 4'b0001, 2'b00, 1'b1, 8'h11);
    tick(4'b0000); chk("rot_idle", 4'b0000, 2'b00, 1'b0, 8'h00);

    // Single request, then idle holds select with dout forced to 0
    tick(4'b0100); chk("single", 4'b0100, 2'b10, 1'b1, 8'hA5);
    tick(4'b0100); chk("single_hold", 4'b0100, 2'b10, 1'b1, 8'hA5);
    i2 = 8'h5A; #1;
    chk("dout_follow", 4'b0100, 2'b10, 1'b1, 8'h5A);
    tick(4'b0000); chk("idle_sel_hold", 4'b0000, 2'b10, 1'b0, 8'h00);

    // Release with no others, then re-arbitrate from last=1
    tick(4'b0010); chk("rel_grant", 4'b0010, 2'b01, 1'b1, 8'h22);
    tick(4'b0000); chk("rel_idle", 4'b0000, 2'b01, 1'b0, 8'h00);
    tick(4'b0011); chk("rel_next", 4'b0001, 2'b00, 1'b1, 8'h11);
    tick(4'b0000);

    // Mid-grant asynchronous reset
    tick(4'b0010); chk("pre_rst", 4'b0010, 2'b01, 1'b1, 8'h22);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 4'b0000, 2'b00, 1'b0, 8'h00);
    @(negedge clk); #1;
    rst_n = 1'b1;
    tick(4'b1010); chk("post_rst", 4'b0010, 2'b01, 1'b1, 8'h22);
    tick(4'b0000);

    // Long hold with a competitor waiting (last=1, so 0 wins first)
    tick(4'b0011); chk("hold_start", 4'b0001, 2'b00, 1'b1, 8'h11);
`ifdef ARB_TIMEOUT_EN
    for (int n = 0; n < 3; n++) begin
      tick(4'b0011); chk("hold_keep", 4'b0001, 2'b00, 1'b1, 8'h11);
    end
    tick(4'b0011); chk("timeout_rot", 4'b0010, 2'b01, 1'b1, 8'h22);
    for (int n = 0; n < 6; n++) tick(4'b0010);
    chk("sat_hold", 4'b0010, 2'b01, 1'b1, 8'h22);
    tick(4'b0011); chk("sat_rot", 4'b0001, 2'b00, 1'b1, 8'h11);
`else
    for (int n = 0; n < 20; n++) begin
      tick(4'b0011); chk("hold_forever", 4'b0001, 2'b00, 1'b1, 8'h11);
    end
`endif
    tick(4'b0000); chk("final_idle", 4'b0000, 2'b00, 1'b0, 8'h00);

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
